// File: rtl/uart_rx_deframer.sv
// UART receive deframer. It looks for an idle-high line, a start bit (0),
// D_WIDTH data bits sent LSB first, and one stop bit (1). Each received word
// is presented on a valid/ready port.
// Handshake: rx_data holds its value while rx_valid=1. A word transfers at a
// posedge where rx_valid && rx_ready. rx_ready is ignored while rx_valid=0.
// If a new word completes while the previous word is still unaccepted, the
// new word replaces the old one and rx_overrun pulses for one cycle.
module uart_rx_deframer #(
    parameter int D_WIDTH      = 9,
    parameter int CLKS_PER_BIT = 1,
    parameter int C_WIDTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               rx_overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Half a bit period. The start bit is re-checked here so that every
    // later sample lands in the middle of its bit.
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]      HALF_LAST = CW'((H > 0) ? H - 1 : 0);
    localparam logic [CW-1:0]      BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [C_WIDTH-1:0] DATA_LAST = C_WIDTH'(D_WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        clk_cnt;
    logic [C_WIDTH-1:0]   bit_cnt;
    logic [D_WIDTH-1:0]   shift_reg;

    // Busy covers the whole frame: start confirmation, data bits and stop bit.
    assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

    // Frame FSM, sampling counters, output word register and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            rx_overrun <= 1'b0;

            // A completing word later in this block overrides this clear.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        // With one clock per bit, this sample is already the
                        // mid-bit confirmation of the start bit.
                        state   <= (H == 0) ? DATA : START;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        // A line that has returned high was a glitch, not a start.
                        state   <= rx ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        // Bits arrive LSB first. Shifting in at the MSB moves
                        // bit 0 into the LSB position by the end of the frame.
                        shift_reg <= {rx, shift_reg[D_WIDTH-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx) begin
                            rx_data    <= shift_reg;
                            rx_valid   <= 1'b1;
                            rx_overrun <= rx_valid && !rx_ready;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ERR;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                ERR: begin
                    // Wait for the line to return to idle before looking
                    // for another start bit.
                    if (rx) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
